// File: rtl/duty_setpoint_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : duty_setpoint_ctrl
// Purpose  : Button-driven duty setpoint with rate-limited slew and
//            period-aligned hand-off of duty/frequency mode to the PWM stage.
// Revision : 1.0
// ============================================================================
module duty_setpoint_ctrl #(
    parameter int DUTY_W    = 7,
    parameter int DUTY_MAX  = 100,
    parameter int STEP      = 5,
    parameter int DB_CYCLES = 100000,
    parameter int RAMP_DIV  = 10416
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              btn_up_i,
    input  logic              btn_dn_i,
    input  logic              btn_mode_i,
    input  logic              period_tick_i,
    output logic [DUTY_W-1:0] duty_o,
    output logic              sel_o,
    output logic              update_o,
    output logic              busy_o
);

    localparam int              c_db_w     = $clog2(DB_CYCLES + 1);
    localparam int              c_ramp_w   = $clog2(RAMP_DIV + 1);
    localparam logic [DUTY_W:0] c_step_ext = (DUTY_W + 1)'(STEP);
    localparam logic [DUTY_W:0] c_max_ext  = (DUTY_W + 1)'(DUTY_MAX);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP      = 2'd1,
        SWITCH_DN = 2'd2
    } state_t;

    logic [2:0] btn_raw_w;
    logic [2:0] press_w;

    assign btn_raw_w = {btn_mode_i, btn_dn_i, btn_up_i};

    // Per button: two-flop synchronizer, stability counter, rising-edge pulse.
    for (genvar i = 0; i < 3; i++) begin : g_btn
        logic              sync1_q, sync1_d;
        logic              sync2_q, sync2_d;
        logic              lvl_q, lvl_d;
        logic              dly_q, dly_d;
        logic              press_q, press_d;
        logic [c_db_w-1:0] cnt_q, cnt_d;

        always_comb begin
            sync1_d = btn_raw_w[i];
            sync2_d = sync1_q;
            lvl_d   = lvl_q;
            cnt_d   = '0;
            if (sync2_q != lvl_q) begin
                if (cnt_q == c_db_w'(DB_CYCLES - 1)) begin
                    lvl_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            dly_d   = lvl_q;
            press_d = lvl_q & ~dly_q;
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                lvl_q   <= 1'b0;
                dly_q   <= 1'b0;
                press_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                sync1_q <= sync1_d;
                sync2_q <= sync2_d;
                lvl_q   <= lvl_d;
                dly_q   <= dly_d;
                press_q <= press_d;
                cnt_q   <= cnt_d;
            end
        end

        assign press_w[i] = press_q;
    end

    state_t              state_q, state_d;
    logic [DUTY_W-1:0]   target_q, target_d;
    logic [DUTY_W-1:0]   cur_q, cur_d;
    logic [DUTY_W-1:0]   duty_q, duty_d;
    logic                sel_q, sel_d;
    logic                update_q, update_d;
    logic                busy_q, busy_d;
    logic [c_ramp_w-1:0] ramp_cnt_q, ramp_cnt_d;

    logic              up_w, dn_w, mode_w, step_w;
    logic [DUTY_W:0]   sum_w;
    logic [DUTY_W-1:0] toward_w;

    // Simultaneous up and down cancel each other.
    assign up_w     = press_w[0] & ~press_w[1];
    assign dn_w     = press_w[1] & ~press_w[0];
    assign mode_w   = press_w[2];
    assign step_w   = (state_q != IDLE) && (ramp_cnt_q == c_ramp_w'(RAMP_DIV - 1));
    assign sum_w    = {1'b0, target_q} + c_step_ext;
    assign toward_w = (cur_q < target_q) ? cur_q + 1'b1 :
                      (cur_q > target_q) ? cur_q - 1'b1 : cur_q;

    always_comb begin
        target_d   = target_q;
        cur_d      = cur_q;
        state_d    = state_q;
        sel_d      = sel_q;
        duty_d     = duty_q;
        update_d   = 1'b0;
        ramp_cnt_d = (state_q == IDLE || step_w) ? '0 : ramp_cnt_q + 1'b1;

        if (up_w) begin
            target_d = (sum_w > c_max_ext) ? c_max_ext[DUTY_W-1:0] : sum_w[DUTY_W-1:0];
        end else if (dn_w) begin
            target_d = ({1'b0, target_q} < c_step_ext) ? '0 : target_q - DUTY_W'(STEP);
        end

        case (state_q)
            IDLE: begin
                if (mode_w) begin
                    state_d = SWITCH_DN;
                end else if (target_d != cur_q) begin
                    state_d = RAMP;
                end
            end
            RAMP: begin
                if (step_w) begin
                    cur_d = toward_w;
                end
                if (mode_w) begin
                    state_d = SWITCH_DN;
                end else if (step_w && toward_w == target_q) begin
                    state_d = IDLE;
                end
            end
            SWITCH_DN: begin
                if (step_w && cur_q != '0) begin
                    cur_d = cur_q - 1'b1;
                end
                // Mode flips only once the PWM stage is already outputting zero.
                if (cur_q == '0 && duty_q == '0 && period_tick_i) begin
                    sel_d   = ~sel_q;
                    state_d = (target_d != '0) ? RAMP : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (period_tick_i && cur_q != duty_q) begin
            duty_d   = cur_q;
            update_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            target_q   <= '0;
            cur_q      <= '0;
            duty_q     <= '0;
            sel_q      <= 1'b0;
            update_q   <= 1'b0;
            busy_q     <= 1'b0;
            ramp_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            cur_q      <= cur_d;
            duty_q     <= duty_d;
            sel_q      <= sel_d;
            update_q   <= update_d;
            busy_q     <= busy_d;
            ramp_cnt_q <= ramp_cnt_d;
        end
    end

    assign duty_o   = duty_q;
    assign sel_o    = sel_q;
    assign update_o = update_q;
    assign busy_o   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_duty_setpoint_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_duty_setpoint_ctrl
// Purpose  : Self-checking bench for duty_setpoint_ctrl (small debounce/ramp).
// Revision : 1.0
// ============================================================================
module tb_duty_setpoint_ctrl;

    localparam int DUTY_W = 7;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              btn_up_i, btn_dn_i, btn_mode_i;
    logic              period_tick_i;
    logic [DUTY_W-1:0] duty_o;
    logic              sel_o, update_o, busy_o;

    duty_setpoint_ctrl #(
        .DUTY_W   (DUTY_W),
        .DUTY_MAX (100),
        .STEP     (5),
        .DB_CYCLES(4),
        .RAMP_DIV (3)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .btn_up_i     (btn_up_i),
        .btn_dn_i     (btn_dn_i),
        .btn_mode_i   (btn_mode_i),
        .period_tick_i(period_tick_i),
        .duty_o       (duty_o),
        .sel_o        (sel_o),
        .update_o     (update_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Period tick: one cycle in every eight.
    int tick_cnt = 0;
    initial begin
        period_tick_i = 1'b0;
        forever begin
            @(negedge clk_i);
            tick_cnt++;
            period_tick_i = (tick_cnt % 8 == 0);
        end
    end

    // Output-timing monitor: duty changes only with update_o right after a tick,
    // and sel_o only changes while duty_o is zero.
    logic              tick_seen = 1'b0;
    logic              mon_en = 1'b0;
    logic [DUTY_W-1:0] prev_duty = '0;
    logic              prev_sel = 1'b0;

    always @(posedge clk_i) tick_seen <= period_tick_i;

    always @(negedge clk_i) begin
        if (mon_en && !rst_i) begin
            if (duty_o != prev_duty || update_o)
                chk("update_timing", int'({duty_o != prev_duty, update_o, tick_seen}), 7);
            if (sel_o != prev_sel)
                chk("sel_change_at_zero", int'(duty_o), 0);
        end
        prev_duty = duty_o;
        prev_sel  = sel_o;
    end

    typedef struct {
        int duty;
        int sel;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        int n_up;
        int n_dn;
        int n_mode;
        int exp_duty;
        int exp_sel;
    } vec_t;
    vec_t vecs[10];

    task automatic press(input logic u, input logic d, input logic m);
        @(negedge clk_i);
        btn_up_i   = u;
        btn_dn_i   = d;
        btn_mode_i = m;
        repeat (8) @(negedge clk_i);
        btn_up_i   = 1'b0;
        btn_dn_i   = 1'b0;
        btn_mode_i = 1'b0;
        repeat (10) @(negedge clk_i);
    endtask

    task automatic settle_and_check(input string tag);
        exp_t e;
        int   t = 0;
        while (busy_o && t < 3000) begin
            @(negedge clk_i);
            t++;
        end
        chk({tag, "_busy_clear"}, int'(busy_o), 0);
        repeat (20) @(negedge clk_i);
        e = sb_q.pop_front();
        chk({tag, "_duty"}, int'(duty_o), e.duty);
        chk({tag, "_sel"}, int'(sel_o), e.sel);
        chk({tag, "_busy_idle"}, int'(busy_o), 0);
    endtask

    task automatic glitch_and_simultaneous();
        int busy_seen = 0;
        @(negedge clk_i);
        btn_up_i = 1'b1;
        repeat (3) @(negedge clk_i);
        btn_up_i = 1'b0;
        repeat (20) begin
            @(negedge clk_i);
            if (busy_o) busy_seen = 1;
        end
        chk("glitch_no_press", busy_seen, 0);
        sb_q.push_back('{duty: 50, sel: 0});
        settle_and_check("glitch");

        busy_seen = 0;
        fork
            press(1'b1, 1'b1, 1'b0);
            repeat (18) begin
                @(negedge clk_i);
                if (busy_o) busy_seen = 1;
            end
        join
        chk("updn_ignored_busy", busy_seen, 0);
        sb_q.push_back('{duty: 50, sel: 0});
        settle_and_check("updn");
    endtask

    task automatic mode_switch();
        int zero_c = -1;
        int sel_c = -1;
        int busy_seen = 0;
        sb_q.push_back('{duty: 40, sel: 1});
        @(negedge clk_i);
        btn_mode_i = 1'b1;
        for (int c = 1; c <= 1000 && sel_c < 0; c++) begin
            @(negedge clk_i);
            if (c == 8) btn_mode_i = 1'b0;
            if (busy_o) busy_seen = 1;
            if (zero_c < 0 && duty_o == '0) zero_c = c;
            if (sel_o) sel_c = c;
        end
        btn_mode_i = 1'b0;
        chk("mode_busy", busy_seen, 1);
        chk("mode_zero_seen", int'(zero_c > 0), 1);
        chk("sel_on_first_zero_tick", sel_c - zero_c, 8);
        settle_and_check("mode");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rise = -1;
        int fall = -1;
        int hit = 0;
        int quiet = 1;

        vecs[0] = '{21, 0, 0, 100, 0};
        vecs[1] = '{0, 22, 0, 0, 0};
        vecs[2] = '{10, 0, 0, 50, 0};
        vecs[3] = '{0, 2, 0, 40, 0};
        vecs[4] = '{1, 0, 0, 45, 1};
        vecs[5] = '{0, 9, 0, 0, 1};
        vecs[6] = '{3, 0, 0, 15, 1};
        vecs[7] = '{0, 0, 1, 15, 0};
        vecs[8] = '{0, 3, 0, 0, 0};
        vecs[9] = '{0, 0, 1, 0, 1};

        rst_i      = 1'b1;
        btn_up_i   = 1'b0;
        btn_dn_i   = 1'b0;
        btn_mode_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("reset_duty", int'(duty_o), 0);
        chk("reset_sel", int'(sel_o), 0);
        chk("reset_update", int'(update_o), 0);
        chk("reset_busy", int'(busy_o), 0);
        rst_i = 1'b0;
        repeat (4) @(negedge clk_i);
        mon_en = 1'b1;

        // Single held press: busy rises 8 edges after the first sampling edge,
        // then five ramp steps of three cycles each.
        sb_q.push_back('{duty: 5, sel: 0});
        btn_up_i = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk_i);
            #1;
            if (busy_o && rise < 0) rise = c;
            if (!busy_o && rise >= 0 && fall < 0) fall = c;
            if (c == 20) btn_up_i = 1'b0;
        end
        chk("press_latency", rise, 8);
        chk("ramp_length", fall - rise, 15);
        settle_and_check("first_press");

        for (int i = 0; i < 10; i++) begin
            sb_q.push_back('{duty: vecs[i].exp_duty, sel: vecs[i].exp_sel});
            repeat (vecs[i].n_up)   press(1'b1, 1'b0, 1'b0);
            repeat (vecs[i].n_dn)   press(1'b0, 1'b1, 1'b0);
            repeat (vecs[i].n_mode) press(1'b0, 1'b0, 1'b1);
            settle_and_check($sformatf("vec%0d", i));
            if (i == 2) glitch_and_simultaneous();
            if (i == 3) mode_switch();
        end

        // Reset in the middle of an upward ramp with sel_o=1.
        for (int c = 0; c < 400 && hit == 0; c++) begin
            @(negedge clk_i);
            btn_up_i = ((c % 18) < 8);
            if (busy_o && duty_o >= 7'd17) hit = 1;
        end
        chk("reach_mid_ramp", hit, 1);
        @(posedge clk_i);
        #2;
        rst_i    = 1'b1;
        btn_up_i = 1'b0;
        #1;
        chk("async_rst_duty", int'(duty_o), 0);
        chk("async_rst_sel", int'(sel_o), 0);
        chk("async_rst_busy", int'(busy_o), 0);
        chk("async_rst_update", int'(update_o), 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (40) begin
            @(negedge clk_i);
            if (busy_o || duty_o != '0 || update_o || sel_o) quiet = 0;
        end
        chk("quiet_after_reset", quiet, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/duty_setpoint_ctrl.md
Name: duty_setpoint_ctrl

Overview:
Upstream setpoint stage for the PWM generator. Debounces three user buttons (up, down, mode) and keeps a target duty. It slews the live duty toward that target at a bounded rate. The duty output and frequency-mode select it drives to the PWM stage change only on PWM period boundaries.

Parameters:
DUTY_W, 7, width of duty values.
DUTY_MAX, 100, upper saturation limit for target duty (must be <= 2^DUTY_W - 1).
STEP, 5, target increment/decrement per button press (>= 1).
DB_CYCLES, 100000, consecutive stable cycles required to accept a button level change (10 ms at 10 MHz).
RAMP_DIV, 10416, clock cycles per 1-LSB slew step of the live duty.

Ports:
clk_i  input  1  system clock.
rst_i  input  1  reset, asynchronous, active-high.
btn_up_i  input  1  raw asynchronous button, raise duty.
btn_dn_i  input  1  raw asynchronous button, lower duty.
btn_mode_i  input  1  raw asynchronous button, toggle frequency mode.
period_tick_i  input  1  one-cycle pulse from PWM stage at start of each PWM period.
duty_o  output  DUTY_W  duty value presented to PWM stage.
sel_o  output  1  frequency mode to PWM stage (0 = 960 Hz, 1 = 50 Hz servo).
update_o  output  1  one-cycle pulse in the cycle duty_o takes a new value.
busy_o  output  1  high while state != IDLE.

Behaviour:
- Reset (async, rst_i=1): duty_o=0, sel_o=0, update_o=0, busy_o=0; target=0, cur=0; state IDLE; debounced levels 0; ramp counter 0.
- Input path per button: 2-flop synchronizer, then debouncer.
  - Debounced level flips only after the synced value differs from it for DB_CYCLES consecutive cycles.
  - Any agreeing cycle clears the debounce counter.
  - Press = one-cycle pulse on debounced 0->1. Releases generate nothing.
  - Press pulse is high in cycle N+DB_CYCLES+2, where N is the first edge sampling raw=1, for a clean input.
- Target arithmetic uses DUTY_W+1 bits:
  - Up press: target = min(target+STEP, DUTY_MAX).
  - Down press: target = max(target-STEP, 0), with no underflow.
  - Up and down presses in the same cycle: both ignored.
- Ramp prescaler counts 0..RAMP_DIV-1 and issues a step on terminal count.
  - It is held at 0 in IDLE and free-runs in RAMP and SWITCH_DN.
  - The first step occurs RAMP_DIV cycles after leaving IDLE.
- FSM:
  - IDLE: cur==target.
    - Mode press -> SWITCH_DN.
    - Else target changes to != cur -> RAMP.
  - RAMP: on each step, cur moves 1 LSB toward target.
    - cur==target after the step -> IDLE.
    - Up/down presses keep updating target; the direction may reverse mid-ramp.
    - Mode press -> SWITCH_DN (mode takes priority over same-cycle up/down for the state transition; target still updates).
  - SWITCH_DN: on each step, cur moves 1 LSB toward 0, ignoring target.
    - Up/down presses still update target. Further mode presses are ignored.
    - When cur==0 and duty_o==0, wait for period_tick_i.
    - On that edge: sel_o toggles, then go to RAMP if target!=0, else IDLE.
- duty_o register: on an edge with period_tick_i=1 and cur!=duty_o, duty_o<=cur and update_o<=1 for exactly that following cycle. Otherwise duty_o holds and update_o=0.
  - sel_o only changes while duty_o==0.
  - Neither output changes between period ticks.
- busy_o = (state != IDLE), registered with state.
- Reset mid-ramp or mid-switch: all state returns to reset values immediately. No pulse on update_o.

Test Plan:
- Bench params DB_CYCLES=4, RAMP_DIV=3, STEP=5, DUTY_MAX=100; period_tick every 8 cycles.
- Reset, hold btn_up high 20 cycles -> single press at N+6; target=5; cur reaches 5 after 15 cycles; duty_o=5 with one update_o pulse at next tick; busy_o low after.
- 21 up presses -> target saturates at 100, never 105; then 22 down presses -> target 0, duty_o settles to 0.
- btn_up glitch high 3 cycles then low -> no press, target unchanged, busy_o stays 0; simultaneous up+dn press at target 50 -> target stays 50.
- At duty_o=40, sel_o=0, mode press -> busy_o=1, cur ramps to 0; sel_o toggles to 1 only on the first tick with duty_o==0; then ramps back to 40.
- Assert rst_i mid-ramp (cur=17) -> duty_o=0, sel_o=0, busy_o=0, update_o=0 within same cycle; no activity until next press.
